fpu_operand_entry: RTL and testbench
====================================

Name: fpu_operand_entry

Overview:
User-input front end for the 16-bit IEEE-754 half-precision FPU on the DE2 board, and the input-side counterpart of the hex display path. It debounces two push-buttons and collects hex digits from four slide switches to build operand A, then operand B, one nibble at a time. It issues both operands to the FPU over a valid/ready handshake, captures the result, and drives the 16-bit word shown on the four 7-segment displays.

Parameters:
DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles a synchronized button level must hold before it is accepted (20 ms at 50 MHz); legal range 1 to 2^24-1.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
digit_in  input  4  hex digit from SW[3:0]; sampled on accepted load press, no synchronizer required
btn_load_n  input  1  raw push-button, active-low: append digit / start new entry
btn_clear_n  input  1  raw push-button, active-low: clear current entry
op_a  output  16  operand A register
op_b  output  16  operand B register
op_valid  output  1  operands offered to FPU
op_ready  input  1  FPU accepts operands
result_in  input  16  FPU result
result_valid  input  1  one-cycle result strobe
disp_word  output  16  word for the 4-digit hex display
digit_cnt  output  2  digits already entered into the current operand (0..3)
phase  output  3  state code: 0 ENTER_A, 1 ENTER_B, 2 ISSUE, 3 WAIT_RES, 4 SHOW

Behaviour:
- Reset (sync, rst=1 at edge): state ENTER_A; op_a=op_b=result reg=0; op_valid=0; digit_cnt=0; disp_word=0; debounced levels=released (1); debounce counters=0; sync flops=1.
- Button conditioning, per button:
  - Input passes through a 2-flop synchronizer.
  - The counter increments while the synced level differs from the debounced level. It resets to 0 when the levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter returns to 0.
  - A press event is a 1-cycle pulse on a debounced 1->0 transition. Release generates no event.
  - Latency: a raw low level first sampled at edge E, and held, causes the register update at edge E+DEBOUNCE_CYCLES+3.
- Simultaneous load and clear events: clear wins; load is discarded.
- ENTER_A:
  - Load event: op_a <= {op_a[11:0], digit_in}; digit_cnt++. On the 4th digit (digit_cnt was 3), go to ENTER_B with digit_cnt=0.
  - Clear event: op_a=0, digit_cnt=0.
- ENTER_B: same rules applied to op_b. The 4th digit moves to ISSUE.
- ISSUE:
  - op_valid=1 (registered; asserts the cycle after entry).
  - When op_valid=1 and op_ready=1 at an edge, the transfer happens: op_valid=0 next cycle, go to WAIT_RES.
  - op_ready already high when op_valid rises means a transfer on that first edge.
  - op_a and op_b are held stable while op_valid=1.
  - Button events are ignored.
- WAIT_RES:
  - result_valid=1: result reg <= result_in, go to SHOW.
  - Button events are ignored. result_valid in any other state is ignored.
  - No timeout. Only rst exits a hung FPU.
- SHOW:
  - Load event: op_a=op_b=0, digit_cnt=0, go to ENTER_A. The digit is NOT consumed.
  - Clear event: same effect as load.
- disp_word (registered from next-state values, so it updates on the same edge as the register it mirrors): ENTER_A -> op_a; ENTER_B, ISSUE, WAIT_RES -> op_b; SHOW -> result reg.
- digit_cnt reads 0 in ISSUE, WAIT_RES and SHOW.
- Unused phase codes 5-7 recover to ENTER_A on the next edge, with all registers cleared as on reset.
- Reset asserted mid-operation (including while op_valid=1) aborts immediately. Any pending debounce count is discarded.

Test Plan:
1. DEBOUNCE_CYCLES=4. After reset, check all outputs are 0 and phase=0. Drive a btn_load_n low pulse of 3 cycles -> no event, op_a stays 0000.
2. Enter A: digits 3,C,0,0 with held presses -> op_a=0x3C00, phase goes 0->1 on the 4th digit, disp_word=0x3C00 then 0x0000 after the switch. Check one press lands exactly at E+7.
3. Enter B=0x4000, with op_ready held low 5 cycles then high -> op_valid high for 6 cycles, operands stable, phase 2->3, single transfer.
4. In WAIT_RES, pulse result_valid with result_in=0x4600 -> phase=4, disp_word=0x4600. A second result_valid pulse is ignored. Then a load press -> phase 0, op_a=op_b=0, digit_cnt=0.
5. In ENTER_B after 2 digits (op_b=0x0012), press both buttons whose events coincide -> op_b=0, digit_cnt=0, op_a unchanged.
6. Assert rst while op_valid=1 -> next cycle op_valid=0, phase 0, all registers 0. Button bounce (alternating levels every 2 cycles for 20 cycles) produces zero events.

Source files
------------

// File: rtl/fpu_operand_entry.sv
// Push-button / slide-switch front end for the half-precision FPU: assembles operand A
// then operand B one hex nibble at a time, issues them over valid/ready, holds the result.
module fpu_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        btn_load_n,
  input  logic        btn_clear_n,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic [15:0] result_in,
  input  logic        result_valid,
  output logic [15:0] disp_word,
  output logic [1:0]  digit_cnt,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    SHOW     = 3'd4
  } state_e;

  localparam logic [23:0] CntMax = 24'(DEBOUNCE_CYCLES);

  // Index 0 is the load button, index 1 the clear button.
  logic [1:0]  btnRaw;
  logic [1:0]  sync1_q, sync2_q, deb_q, debPrev_q, press;
  logic [23:0] cnt_q [2];
  logic        loadEvt, clearEvt;

  state_e      state_q, state_d;
  logic [15:0] opA_q, opA_d, opB_q, opB_d;
  logic [15:0] result_q, result_d, disp_q, disp_d;
  logic [1:0]  digitCnt_q, digitCnt_d;
  logic        opValid_q, opValid_d;

  assign btnRaw = {btn_clear_n, btn_load_n};

  // A level is accepted one edge after the mismatch count has reached DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_q     <= 2'b11;
      debPrev_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btnRaw;
      sync2_q   <= sync1_q;
      debPrev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 24'd1;
        end
      end
    end
  end

  assign press    = debPrev_q & ~deb_q;
  assign clearEvt = press[1];
  assign loadEvt  = press[0] & ~press[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTER_A;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      disp_q     <= '0;
      digitCnt_q <= '0;
      opValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      result_q   <= result_d;
      disp_q     <= disp_d;
      digitCnt_q <= digitCnt_d;
      opValid_q  <= opValid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    result_d   = result_q;
    digitCnt_d = digitCnt_q;
    opValid_d  = opValid_q;
    case (state_q)
      ENTER_A: begin
        if (clearEvt) begin
          opA_d      = '0;
          digitCnt_d = '0;
        end else if (loadEvt) begin
          opA_d = {opA_q[11:0], digit_in};
          if (digitCnt_q == 2'd3) begin
            digitCnt_d = '0;
            state_d    = ENTER_B;
          end else begin
            digitCnt_d = digitCnt_q + 2'd1;
          end
        end
      end
      ENTER_B: begin
        if (clearEvt) begin
          opB_d      = '0;
          digitCnt_d = '0;
        end else if (loadEvt) begin
          opB_d = {opB_q[11:0], digit_in};
          if (digitCnt_q == 2'd3) begin
            digitCnt_d = '0;
            state_d    = ISSUE;
          end else begin
            digitCnt_d = digitCnt_q + 2'd1;
          end
        end
      end
      ISSUE: begin
        if (opValid_q && op_ready) begin
          opValid_d = 1'b0;
          state_d   = WAIT_RES;
        end else begin
          opValid_d = 1'b1;
        end
      end
      WAIT_RES: begin
        if (result_valid) begin
          result_d = result_in;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (loadEvt || clearEvt) begin
          opA_d      = '0;
          opB_d      = '0;
          digitCnt_d = '0;
          state_d    = ENTER_A;
        end
      end
      default: begin
        state_d    = ENTER_A;
        opA_d      = '0;
        opB_d      = '0;
        result_d   = '0;
        digitCnt_d = '0;
        opValid_d  = 1'b0;
      end
    endcase

    // Display follows the next-state values so it moves on the same edge as its source.
    disp_d = '0;
    case (state_d)
      ENTER_A:                 disp_d = opA_d;
      ENTER_B, ISSUE, WAIT_RES: disp_d = opB_d;
      SHOW:                    disp_d = result_d;
      default:                 disp_d = '0;
    endcase
  end

  assign op_a      = opA_q;
  assign op_b      = opB_q;
  assign op_valid  = opValid_q;
  assign disp_word = disp_q;
  assign digit_cnt = digitCnt_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_fpu_operand_entry.sv
// Scoreboard bench for fpu_operand_entry with a short debounce window so presses
// resolve in a handful of cycles.
module tb_fpu_operand_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  digit_in = 4'h0;
  logic        btn_load_n = 1'b1;
  logic        btn_clear_n = 1'b1;
  logic        op_ready = 1'b0;
  logic [15:0] result_in = 16'h0;
  logic        result_valid = 1'b0;
  logic [15:0] op_a, op_b, disp_word;
  logic        op_valid;
  logic [1:0]  digit_cnt;
  logic [2:0]  phase;

  fpu_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in),
    .btn_load_n(btn_load_n), .btn_clear_n(btn_clear_n),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .result_in(result_in), .result_valid(result_valid),
    .disp_word(disp_word), .digit_cnt(digit_cnt), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  phase;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] disp;
    logic [1:0]  cnt;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] xferQ[$];

  int checks = 0;
  int errors = 0;
  int validCycles = 0;
  int xferCount = 0;

  logic [15:0] mA = 16'h0, mB = 16'h0, mRes = 16'h0;
  logic [2:0]  mPhase = 3'd0;
  logic [1:0]  mCnt = 2'd0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] expDisp();
    case (mPhase)
      3'd0:             return mA;
      3'd1, 3'd2, 3'd3: return mB;
      3'd4:             return mRes;
      default:          return 16'h0;
    endcase
  endfunction

  // Sampled at the rising edge before NBA updates, i.e. the values the DUT acts on.
  always @(posedge clk) begin
    if (!rst && op_valid) begin
      validCycles++;
      checkOutput("stableOpA", op_a, mA);
      checkOutput("stableOpB", op_b, mB);
      if (op_ready) begin
        xferCount++;
        checkOutput("xferPending", 32'(xferQ.size() > 0), 32'd1);
        if (xferQ.size() > 0) begin
          logic [31:0] x;
          x = xferQ.pop_front();
          checkOutput("xferOpA", op_a, x[31:16]);
          checkOutput("xferOpB", op_b, x[15:0]);
        end
      end
    end
  end

  // One button action: update the model, push the expected state, then compare
  // one edge before and exactly at E+7 (E = first edge that samples the press).
  task automatic applyStimulus(input bit load, input bit clear, input logic [3:0] digit, input bit settle);
    exp_t        e;
    logic [15:0] dispBefore;
    @(negedge clk);
    dispBefore  = disp_word;
    digit_in    = digit;
    btn_load_n  = !load;
    btn_clear_n = !clear;
    if (mPhase == 3'd0 || mPhase == 3'd1) begin
      if (clear) begin
        if (mPhase == 3'd0) mA = 16'h0; else mB = 16'h0;
        mCnt = 2'd0;
      end else if (load) begin
        if (mPhase == 3'd0) mA = {mA[11:0], digit}; else mB = {mB[11:0], digit};
        if (mCnt == 2'd3) begin
          mCnt   = 2'd0;
          mPhase = mPhase + 3'd1;
          if (mPhase == 3'd2) xferQ.push_back({mA, mB});
        end else begin
          mCnt = mCnt + 2'd1;
        end
      end
    end else if (mPhase == 3'd4 && (load || clear)) begin
      mA = 16'h0; mB = 16'h0; mCnt = 2'd0; mPhase = 3'd0;
    end
    e.phase = mPhase; e.a = mA; e.b = mB; e.cnt = mCnt; e.disp = expDisp();
    expQ.push_back(e);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("notEarlyDisp", disp_word, dispBefore);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput("pressPhase", phase, e.phase);
    checkOutput("pressOpA", op_a, e.a);
    checkOutput("pressOpB", op_b, e.b);
    checkOutput("pressCnt", digit_cnt, e.cnt);
    checkOutput("pressDisp", disp_word, e.disp);
    @(negedge clk);
    btn_load_n  = 1'b1;
    btn_clear_n = 1'b1;
    if (settle) repeat (12) @(negedge clk);
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstPhase", phase, 3'd0);
    checkOutput("rstOpA", op_a, 16'h0);
    checkOutput("rstOpB", op_b, 16'h0);
    checkOutput("rstDisp", disp_word, 16'h0);
    checkOutput("rstCnt", digit_cnt, 2'd0);
    checkOutput("rstValid", op_valid, 1'b0);

    // Too-short press plus a stray result strobe: neither may change anything.
    @(negedge clk);
    btn_load_n = 1'b0; digit_in = 4'h9; result_valid = 1'b1; result_in = 16'hBEEF;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    btn_load_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("shortOpA", op_a, 16'h0);
    checkOutput("shortCnt", digit_cnt, 2'd0);
    checkOutput("shortPhase", phase, 3'd0);
    checkOutput("shortDisp", disp_word, 16'h0);

    applyStimulus(1, 0, 4'h3, 1);
    applyStimulus(1, 0, 4'hC, 1);
    applyStimulus(1, 0, 4'h0, 1);
    applyStimulus(1, 0, 4'h0, 1);

    applyStimulus(1, 0, 4'h4, 1);
    applyStimulus(1, 0, 4'h0, 1);
    applyStimulus(1, 0, 4'h0, 1);
    applyStimulus(1, 0, 4'h0, 0);
    snap = validCycles;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("xferValidDrop", op_valid, 1'b0);
    checkOutput("xferPhase", phase, 3'd3);
    checkOutput("validCycles", validCycles - snap, 6);
    checkOutput("xferCount", xferCount, 1);
    checkOutput("waitDisp", disp_word, 16'h4000);
    mPhase = 3'd3;

    @(negedge clk);
    op_ready = 1'b0; result_in = 16'h4600; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0; result_in = 16'h0;
    mRes = 16'h4600; mPhase = 3'd4;
    checkOutput("showPhase", phase, 3'd4);
    checkOutput("showDisp", disp_word, 16'h4600);
    result_in = 16'h1234; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
    checkOutput("secondResPhase", phase, 3'd4);
    checkOutput("secondResDisp", disp_word, 16'h4600);
    applyStimulus(1, 0, 4'h7, 1);

    applyStimulus(1, 0, 4'h1, 1);
    applyStimulus(1, 0, 4'h2, 1);
    applyStimulus(1, 0, 4'h3, 1);
    applyStimulus(1, 0, 4'h4, 1);
    applyStimulus(1, 0, 4'h1, 1);
    applyStimulus(1, 0, 4'h2, 1);
    applyStimulus(1, 1, 4'h5, 1);

    applyStimulus(1, 0, 4'h4, 1);
    applyStimulus(1, 0, 4'h0, 1);
    applyStimulus(1, 0, 4'h0, 1);
    applyStimulus(1, 0, 4'h0, 0);
    repeat (3) @(negedge clk);
    checkOutput("preRstValid", op_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortValid", op_valid, 1'b0);
    checkOutput("abortPhase", phase, 3'd0);
    checkOutput("abortOpA", op_a, 16'h0);
    checkOutput("abortOpB", op_b, 16'h0);
    checkOutput("abortDisp", disp_word, 16'h0);
    checkOutput("abortCnt", digit_cnt, 2'd0);
    mA = 16'h0; mB = 16'h0; mRes = 16'h0; mPhase = 3'd0; mCnt = 2'd0;
    xferQ.delete();
    @(negedge clk);
    rst = 1'b0;

    digit_in = 4'hF;
    for (int i = 0; i < 5; i++) begin
      btn_load_n = 1'b0;
      repeat (2) @(negedge clk);
      btn_load_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (15) @(negedge clk);
    checkOutput("bounceOpA", op_a, 16'h0);
    checkOutput("bounceCnt", digit_cnt, 2'd0);
    checkOutput("bouncePhase", phase, 3'd0);
    checkOutput("bounceDisp", disp_word, 16'h0);

    applyStimulus(1, 0, 4'hA, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
